// File: rtl/saw_pkg.sv
// Shared constants, frame layout and frame-verdict helper for the sawtooth
// configuration controller.
package saw_pkg;

   localparam int         FRAME_BITS      = 24;
   localparam logic [4:0] FRAME_CNT_FULL  = 5'd24;

   localparam logic [6:0] ADDR_FREQ       = 7'h00;
   localparam logic [6:0] ADDR_VOL        = 7'h01;
   localparam logic [6:0] ADDR_CTRL       = 7'h02;

   localparam logic [7:0]  VOL_RST        = 8'h80;
   localparam logic [15:0] FREQ_RST       = 16'h0000;

   localparam int CTRL_OSC_EN_BIT         = 0;
   localparam int CTRL_TRIG_BIT           = 1;

   typedef struct packed {
      logic        wr;
      logic [6:0]  addr;
      logic [15:0] data;
   } saw_frame_t;

   typedef enum logic [1:0] {
      FRAME_NONE = 2'd0,
      FRAME_OK   = 2'd1,
      FRAME_BAD  = 2'd2
   } frame_verdict_e;

   // ovf flags bits beyond the 24th, which the saturating counter cannot show
   function automatic frame_verdict_e judge_frame(input logic [4:0] cnt, input logic ovf);
      frame_verdict_e v;
      if (ovf) begin
         v = FRAME_BAD;
      end else if (cnt == 5'd0) begin
         v = FRAME_NONE;
      end else if (cnt == FRAME_CNT_FULL) begin
         v = FRAME_OK;
      end else begin
         v = FRAME_BAD;
      end
      return v;
   endfunction

endpackage

// File: rtl/saw_spi_sync.sv
// Brings the asynchronous SPI pins into the clk domain and derives the
// spi_clk rise and spi_nss rise/fall strobes.
module saw_spi_sync (
   input  logic clk,
   input  logic rstn,
   input  logic spi_clk,
   input  logic spi_mosi,
   input  logic spi_nss,
   output logic sclk_rise,
   output logic mosi_lvl,
   output logic nss_lvl,
   output logic nss_rise,
   output logic nss_fall
);

   // pin order in the vectors: {nss, mosi, clk}
   logic [2:0] meta_r;
   logic [2:0] sync_r;
   logic [1:0] last_r;

   // Flops reset low so a chip select already low at reset release never
   // looks like a frame start.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         meta_r <= 3'b000;
         sync_r <= 3'b000;
         last_r <= 2'b00;
      end else begin
         meta_r <= {spi_nss, spi_mosi, spi_clk};
         sync_r <= meta_r;
         last_r <= {sync_r[2], sync_r[0]};
      end
   end

   assign sclk_rise = sync_r[0] & ~last_r[0];
   assign mosi_lvl  = sync_r[1];
   assign nss_lvl   = sync_r[2];
   assign nss_rise  = sync_r[2] & ~last_r[1];
   assign nss_fall  = ~sync_r[2] & last_r[1];

endmodule

// File: rtl/saw_cfg_ctrl.sv
// SPI write-frame decoder, register file and wrap-aligned FREQ scheduler.
// Optional stalled-frame abort is compiled in with SAW_SPI_TIMEOUT_EN.
module saw_cfg_ctrl
   import saw_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        spi_clk,
   input  logic        spi_mosi,
   input  logic        spi_nss,
   input  logic        phase_wrap,
   output logic [15:0] freq_inc,
   output logic [7:0]  volume,
   output logic        osc_en,
   output logic        trig_mode,
   output logic        cfg_stb,
   output logic        frame_err
);

   logic sclk_rise_s;
   logic mosi_s;
   logic nss_s;
   logic nss_rise_s;
   logic nss_fall_s;

   saw_spi_sync u_sync (
      .clk       (clk),
      .rstn      (rstn),
      .spi_clk   (spi_clk),
      .spi_mosi  (spi_mosi),
      .spi_nss   (spi_nss),
      .sclk_rise (sclk_rise_s),
      .mosi_lvl  (mosi_s),
      .nss_lvl   (nss_s),
      .nss_rise  (nss_rise_s),
      .nss_fall  (nss_fall_s)
   );

   logic                 active_r;
   logic [4:0]           bit_cnt_r;
   logic                 ovf_r;
   logic [FRAME_BITS-1:0] shift_r;
   logic                 cfg_stb_r;
   logic                 frame_err_r;
   logic [15:0]          freq_inc_r;
   logic [15:0]          freq_pend_r;
   logic                 pend_valid_r;
   logic [7:0]           volume_r;
   logic                 osc_en_r;
   logic                 trig_mode_r;

   saw_frame_t     frame_s;
   frame_verdict_e verdict_s;
   logic           wr_ok_s;
   logic           freq_wr_s;
   logic           vol_wr_s;
   logic           ctrl_wr_s;
   logic           load_s;
   logic           timeout_s;

   // Frame judgement, address decode and FREQ commit condition.
   always_comb begin
      frame_s   = saw_frame_t'(shift_r);
      verdict_s = judge_frame(bit_cnt_r, ovf_r);
      wr_ok_s   = 1'b0;
      freq_wr_s = 1'b0;
      vol_wr_s  = 1'b0;
      ctrl_wr_s = 1'b0;
      if (nss_rise_s && (verdict_s == FRAME_OK) && frame_s.wr) begin
         wr_ok_s = 1'b1;
      end else begin
         wr_ok_s = 1'b0;
      end
      case (frame_s.addr)
         ADDR_FREQ: freq_wr_s = wr_ok_s;
         ADDR_VOL:  vol_wr_s  = wr_ok_s;
         ADDR_CTRL: ctrl_wr_s = wr_ok_s;
         default: begin
            freq_wr_s = 1'b0;
            vol_wr_s  = 1'b0;
            ctrl_wr_s = 1'b0;
         end
      endcase
      load_s = pend_valid_r & (phase_wrap | ~osc_en_r);
   end

`ifdef SAW_SPI_TIMEOUT_EN
   localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES - 1);

   logic [15:0] idle_cnt_r;
   logic        idle_s;

   // Idle means a partial frame is held with chip select low and no spi_clk edge.
   always_comb begin
      idle_s    = 1'b0;
      timeout_s = 1'b0;
      if (active_r && !nss_s && !sclk_rise_s && !ovf_r &&
          (bit_cnt_r != 5'd0) && (bit_cnt_r != FRAME_CNT_FULL)) begin
         idle_s    = 1'b1;
         timeout_s = (idle_cnt_r == TMO_LIMIT);
      end else begin
         idle_s    = 1'b0;
         timeout_s = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         idle_cnt_r <= 16'd0;
      end else if (idle_s && !timeout_s) begin
         idle_cnt_r <= idle_cnt_r + 16'd1;
      end else begin
         idle_cnt_r <= 16'd0;
      end
   end
`else
   assign timeout_s = 1'b0;

   // The parameter stays on the interface so both builds instantiate alike.
   if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
   end
`endif

   // Shifter and bit counter; a frame is only collected after a seen nss fall.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         active_r    <= 1'b0;
         bit_cnt_r   <= 5'd0;
         ovf_r       <= 1'b0;
         shift_r     <= 24'h000000;
         cfg_stb_r   <= 1'b0;
         frame_err_r <= 1'b0;
      end else begin
         cfg_stb_r   <= 1'b0;
         frame_err_r <= 1'b0;
         if (nss_fall_s) begin
            active_r  <= 1'b1;
            bit_cnt_r <= 5'd0;
            ovf_r     <= 1'b0;
         end else if (nss_rise_s) begin
            active_r    <= 1'b0;
            bit_cnt_r   <= 5'd0;
            ovf_r       <= 1'b0;
            cfg_stb_r   <= wr_ok_s;
            frame_err_r <= (verdict_s == FRAME_BAD);
         end else if (timeout_s) begin
            active_r    <= 1'b0;
            bit_cnt_r   <= 5'd0;
            ovf_r       <= 1'b0;
            frame_err_r <= 1'b1;
         end else if (active_r && !nss_s && sclk_rise_s) begin
            if (bit_cnt_r == FRAME_CNT_FULL) begin
               ovf_r <= 1'b1;
            end else begin
               shift_r   <= {shift_r[FRAME_BITS-2:0], mosi_s};
               bit_cnt_r <= bit_cnt_r + 5'd1;
            end
         end
      end
   end

   // Register file; freq_inc only moves on a wrap or while the oscillator is off.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         freq_inc_r   <= FREQ_RST;
         freq_pend_r  <= FREQ_RST;
         pend_valid_r <= 1'b0;
         volume_r     <= VOL_RST;
         osc_en_r     <= 1'b0;
         trig_mode_r  <= 1'b0;
      end else begin
         if (vol_wr_s) begin
            volume_r <= frame_s.data[7:0];
         end
         if (ctrl_wr_s) begin
            osc_en_r    <= frame_s.data[CTRL_OSC_EN_BIT];
            trig_mode_r <= frame_s.data[CTRL_TRIG_BIT];
         end
         if (load_s) begin
            freq_inc_r <= freq_pend_r;
         end
         if (freq_wr_s) begin
            freq_pend_r  <= frame_s.data;
            pend_valid_r <= 1'b1;
         end else if (load_s) begin
            pend_valid_r <= 1'b0;
         end
      end
   end

   assign freq_inc  = freq_inc_r;
   assign volume    = volume_r;
   assign osc_en    = osc_en_r;
   assign trig_mode = trig_mode_r;
   assign cfg_stb   = cfg_stb_r;
   assign frame_err = frame_err_r;

endmodule

// File: doc/saw_cfg_ctrl.md
# saw_cfg_ctrl

SPI-driven configuration controller for the sawtooth synthesizer core. It receives 24-bit write frames from an external SPI master on the bidirectional PMOD pins and decodes them into a register set: oscillator frequency increment, volume and control. It schedules frequency changes so they take effect only at an oscillator phase wrap. It sits between the top-level pin assignments and the oscillator/output datapath inside `synth_top`.

## Interface
- `TIMEOUT_CYCLES`, default 4096: idle `clk` cycles, with `spi_nss` low and a partial frame held, before abort. Used only with `SAW_SPI_TIMEOUT_EN`.
- `clk` in 1: system clock, single clock domain.
- `rstn` in 1: asynchronous active-low reset.
- `spi_clk` in 1: SPI clock, asynchronous to `clk`.
- `spi_mosi` in 1: SPI data, asynchronous.
- `spi_nss` in 1: SPI chip select, active low, asynchronous.
- `phase_wrap` in 1: one-cycle pulse from the oscillator when its phase accumulator wraps.
- `freq_inc` out 16: active phase increment for the oscillator.
- `volume` out 8: output amplitude scale.
- `osc_en` out 1: oscillator enable (CTRL bit 0).
- `trig_mode` out 1: 0 = free-running, 1 = gated by the trigger button (CTRL bit 1).
- `cfg_stb` out 1: one-cycle pulse on every successful register write.
- `frame_err` out 1: one-cycle pulse on every discarded frame.

## Operation
- All three SPI inputs pass through 2-FF synchronizers, plus a third flop for edge detection. The rising edges of `spi_clk` and `spi_nss` and the falling edge of `spi_nss` are derived in the `clk` domain.
- `spi_clk` frequency must be at most `clk`/4.
- SPI mode 0, MSB first. `spi_mosi` is sampled on each synchronized `spi_clk` rising edge while `spi_nss` is low.
- Frame is 24 bits: cmd[7] = write flag, cmd[6:0] = address, then data[15:0].
- The bit counter clears on the `spi_nss` falling edge. It saturates at 24; further bits are ignored.
- `spi_nss` rising edge with exactly 24 bits received:
  - write flag = 1: execute the write and pulse `cfg_stb`.
  - write flag = 0: accepted, no effect, no pulse.
- `spi_nss` rising edge with 1 to 23 bits, or more than 24 bits: discard the frame and pulse `frame_err`. No register changes.
- `spi_nss` rising edge with 0 bits: no effect.
- Address map:
  - 0x00 FREQ: data[15:0] goes to `freq_pend`.
  - 0x01 VOL: data[7:0] goes to `volume`.
  - 0x02 CTRL: data[1:0] go to {`trig_mode`, `osc_en`}.
  - Any other address: write ignored, `cfg_stb` still pulses.
- FREQ scheduling:
  - A write sets `pend_valid`.
  - `freq_inc` loads `freq_pend` and clears `pend_valid` on a cycle where `pend_valid`=1 and either `phase_wrap`=1 or `osc_en`=0.
  - A second FREQ write before the wrap overwrites `freq_pend`; last write wins.
- Simultaneous FREQ commit and `phase_wrap`: `freq_inc` loads the previous `freq_pend`, if valid. The new value waits for the next wrap.
- A commit to CTRL clearing `osc_en` causes an immediate load of any pending FREQ on the following cycle.
- Reset values: `freq_inc`=0, `freq_pend`=0, `pend_valid`=0, `volume`=0x80, `osc_en`=0, `trig_mode`=0, `cfg_stb`=0, `frame_err`=0, bit counter=0, shift register=0.
- Reset asserted mid-frame: all state returns to reset values. The rest of that frame is discarded, because no falling edge of `spi_nss` is seen after reset.

## Timing
- Synchronizer latency: a pin edge is detected on the 3rd `clk` rising edge after it is first captured.
- Commit: VOL and CTRL outputs and `cfg_stb` change on the same edge that detects the `spi_nss` rise.
- `freq_inc` changes at the earliest 1 cycle after commit, gated by `phase_wrap` or `osc_en`=0.
- `cfg_stb` and `frame_err` are exactly one cycle wide and are never asserted together.
- All outputs are registered.

## Configuration
- `SAW_SPI_TIMEOUT_EN` defined:
  - Condition: `spi_nss` low, bit count 1 to 23, and no `spi_clk` rising edge for `TIMEOUT_CYCLES` cycles.
  - Response: the bit counter clears, `frame_err` pulses, and all bits are ignored until the next `spi_nss` falling edge.
  - A 16-bit idle counter is used.
- Not defined: no idle counter. A stalled frame waits indefinitely and is judged only at the `spi_nss` rise.

## Structure
- Package `saw_pkg` holds:
  - `FRAME_BITS`=24.
  - Address constants `ADDR_FREQ`, `ADDR_VOL`, `ADDR_CTRL`.
  - Reset constants `VOL_RST`=8'h80 and `FREQ_RST`=16'h0000.
  - CTRL bit indices.
- Sub-module `saw_spi_sync` contains the 3-flop synchronizers and edge detectors for the three SPI pins. The parent holds the shifter, decode, register file and FREQ scheduler.

## Test plan
- Write 0x80 0x12 0x34 with `osc_en`=0: `cfg_stb` pulses once, and `freq_inc`=0x1234 one cycle after commit.
- `osc_en`=1, then write FREQ=0x0100: `freq_inc` holds its old value until the `phase_wrap` pulse, then reads 0x0100 on the next edge.
- Send 20 bits and raise `spi_nss`: `frame_err` pulses and all registers are unchanged. Send 25 bits: same result.
- Write VOL=0x00FF, then CTRL=0x0003: `volume`=0xFF, `osc_en`=1, `trig_mode`=1. Write to address 0x05: `cfg_stb` pulses and there is no change.
- Assert `rstn` low at bit 12 of a FREQ write: outputs return to reset values. After release, the remaining bits followed by `spi_nss` high produce no commit.
- With `SAW_SPI_TIMEOUT_EN` and `TIMEOUT_CYCLES`=64: stall after 8 bits. `frame_err` pulses at cycle 64, and the next full frame commits normally.
